// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths, payload layout and zero-register constant for the MEM->WB stage
package mem_wb_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 3;
   localparam int ZERO_REG = 0;
   // payload packs {regwrite, memtoreg, rdata, out, rd} from MSB down to LSB
   localparam int OFF_RD = 0;
   function automatic int off_out(int aw);
      return aw;
   endfunction
   function automatic int off_rdata(int dw, int aw);
      return aw + dw;
   endfunction
   function automatic int off_memtoreg(int dw, int aw);
      return aw + 2 * dw;
   endfunction
   function automatic int off_regwrite(int dw, int aw);
      return aw + 2 * dw + 1;
   endfunction
   function automatic int payload_w(int dw, int aw);
      return aw + 2 * dw + 2;
   endfunction
endpackage

// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if: MEM-side handshake, payload and write-back bundle of the MEM->WB stage
interface mem_wb_pipe_if
   import mem_wb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              in_regwrite;
   logic              in_memtoreg;
   logic [DATA_W-1:0] in_rdata;
   logic [DATA_W-1:0] in_out;
   logic [REG_AW-1:0] in_rd;
   logic              out_valid;
   logic              out_ready;
   logic              wb_regwrite;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_wdata;
   logic [1:0]        occupancy;

   modport master (
      output flush, in_valid, in_regwrite, in_memtoreg, in_rdata, in_out, in_rd, out_ready,
      input  in_ready, out_valid, wb_regwrite, wb_rd, wb_wdata, occupancy
   );
   modport slave (
      input  flush, in_valid, in_regwrite, in_memtoreg, in_rdata, in_out, in_rd, out_ready,
      output in_ready, out_valid, wb_regwrite, wb_rd, wb_wdata, occupancy
   );
endinterface

// File: rtl/mem_wb_pipe_skid_reg.sv
// skid_reg: two-entry elastic register (main + skid) with registered ready and flush
module skid_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occupancy
);
   logic         m_v, s_v;
   logic [W-1:0] m_d, s_d;
   logic         in_fire, out_fire;

   assign in_ready  = !s_v;
   assign in_fire   = in_valid & !s_v & !flush;
   assign out_fire  = m_v & out_ready;
   assign out_valid = m_v;
   assign out_data  = m_d;
   assign occupancy = {1'b0, m_v} + {1'b0, s_v};

   // flush beats everything; skid entry is always older than any new input, so it refills main first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_v <= 1'b0;
         s_v <= 1'b0;
         m_d <= '0;
         s_d <= '0;
      end else if (flush) begin
         m_v <= 1'b0;
         s_v <= 1'b0;
      end else if (out_fire && s_v) begin
         m_d <= s_d;
         s_v <= 1'b0;
      end else if (!m_v || out_fire) begin
         m_v <= in_fire;
         if (in_fire) m_d <= in_data;
      end else if (in_fire) begin
         s_v <= 1'b1;
         s_d <= in_data;
      end
   end
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: stallable MEM->WB stage producing register-file write strobe, address and data
module mem_wb_pipe
   import mem_wb_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_AW  = REG_AW_DEF,
   parameter bit ZERO_RO = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   mem_wb_pipe_if.slave bus
);
   localparam int PW = payload_w(DATA_W, REG_AW);
   localparam int OUT_LO = off_out(REG_AW);
   localparam int RDATA_LO = off_rdata(DATA_W, REG_AW);
   localparam int MTR_BIT = off_memtoreg(DATA_W, REG_AW);
   localparam int RW_BIT = off_regwrite(DATA_W, REG_AW);

   logic [PW-1:0]     in_pl, m_pl;
   logic              m_valid;
   logic [REG_AW-1:0] m_rd;
   logic              zero_dst;

   assign in_pl = {bus.in_regwrite, bus.in_memtoreg, bus.in_rdata, bus.in_out, bus.in_rd};

   skid_reg #(.W(PW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (in_pl),
      .out_valid (m_valid),
      .out_ready (bus.out_ready),
      .out_data  (m_pl),
      .occupancy (bus.occupancy)
   );

   assign m_rd      = m_pl[OFF_RD +: REG_AW];
   assign zero_dst  = ZERO_RO && (m_rd == REG_AW'(ZERO_REG));
   assign bus.out_valid   = m_valid;
   assign bus.wb_rd       = m_rd;
   assign bus.wb_wdata    = m_pl[MTR_BIT] ? m_pl[RDATA_LO +: DATA_W] : m_pl[OUT_LO +: DATA_W];
   assign bus.wb_regwrite = m_valid & bus.out_ready & m_pl[RW_BIT] & !zero_dst;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: scoreboard bench for streaming, stall, flush, zero-reg gating, async reset and a narrow variant
module tb_mem_wb_pipe;
   typedef struct packed {logic rw; logic [2:0] rd; logic [31:0] wd;} exp0_t;
   typedef struct packed {logic rw; logic [3:0] rd; logic [18:0] wd;} exp2_t;
   typedef struct packed {logic rw; logic mtr; logic [31:0] rdata; logic [31:0] out; logic [2:0] rd;} ent0_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int vecs = 0;
   int errs = 0;
   exp0_t sb0[$];
   exp2_t sb2[$];

   mem_wb_pipe_if #(.DATA_W(32), .REG_AW(3)) b0 ();
   mem_wb_pipe_if #(.DATA_W(32), .REG_AW(3)) b1 ();
   mem_wb_pipe_if #(.DATA_W(19), .REG_AW(4)) b2 ();

   mem_wb_pipe #(.DATA_W(32), .REG_AW(3), .ZERO_RO(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   mem_wb_pipe #(.DATA_W(32), .REG_AW(3), .ZERO_RO(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   mem_wb_pipe #(.DATA_W(19), .REG_AW(4), .ZERO_RO(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   always #5 clk = ~clk;

   task automatic set0(input ent0_t e, input logic v, input logic ordy, input logic fl);
      b0.in_valid = v;
      b0.in_regwrite = e.rw;
      b0.in_memtoreg = e.mtr;
      b0.in_rdata = e.rdata;
      b0.in_out = e.out;
      b0.in_rd = e.rd;
      b0.out_ready = ordy;
      b0.flush = fl;
   endtask

   task automatic push0();
      exp0_t e;
      if (b0.in_valid && b0.in_ready && !b0.flush) begin
         e.rw = b0.in_regwrite && (b0.in_rd != 3'd0);
         e.rd = b0.in_rd;
         e.wd = b0.in_memtoreg ? b0.in_rdata : b0.in_out;
         sb0.push_back(e);
      end
   endtask

   task automatic test_reset();
      #2;
      vecs++;
      if ({b0.out_valid, b0.in_ready, b0.wb_regwrite, b0.wb_rd, b0.wb_wdata, b0.occupancy} !== {1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 2'd0}) begin
         errs++;
         $display("FAIL reset0 got ov=%b ir=%b rw=%b rd=%0d wd=%h occ=%0d, required 0 1 0 0 0 0", b0.out_valid, b0.in_ready, b0.wb_regwrite, b0.wb_rd, b0.wb_wdata, b0.occupancy);
      end
      vecs++;
      if ({b2.out_valid, b2.in_ready, b2.wb_regwrite, b2.wb_rd, b2.wb_wdata, b2.occupancy} !== {1'b0, 1'b1, 1'b0, 4'd0, 19'd0, 2'd0}) begin
         errs++;
         $display("FAIL reset2 got ov=%b ir=%b rw=%b rd=%0d wd=%h occ=%0d, required 0 1 0 0 0 0", b2.out_valid, b2.in_ready, b2.wb_regwrite, b2.wb_rd, b2.wb_wdata, b2.occupancy);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      ent0_t e;
      exp0_t x;
      for (int c = 0; c < 12; c++) begin
         if (c == 0) e = '{rw: 1'b1, mtr: 1'b1, rdata: 32'h1234ABCD, out: 32'h0, rd: 3'd5};
         else e = '{rw: c[1] | c[2], mtr: c[0], rdata: $urandom, out: $urandom, rd: c[2:0]};
         set0(e, c < 8, 1'b1, 1'b0);
         @(negedge clk);
         if (c >= 1 && c <= 8) begin
            vecs++;
            if (!b0.out_valid || !b0.in_ready) begin
               errs++;
               $display("FAIL stream_rate cycle %0d got ov=%b ir=%b, required 1 1", c, b0.out_valid, b0.in_ready);
            end
         end
         if (c == 1) begin
            vecs++;
            if ({b0.wb_regwrite, b0.wb_rd, b0.wb_wdata} !== {1'b1, 3'd5, 32'h1234ABCD}) begin
               errs++;
               $display("FAIL stream_first got rw=%b rd=%0d wd=%h, required 1 5 1234abcd", b0.wb_regwrite, b0.wb_rd, b0.wb_wdata);
            end
         end
         if (b0.out_valid && b0.out_ready) begin
            vecs++;
            if (sb0.size() == 0) begin
               errs++;
               $display("FAIL stream_extra got rd=%0d wd=%h, required no output", b0.wb_rd, b0.wb_wdata);
            end else begin
               x = sb0.pop_front();
               if ({b0.wb_regwrite, b0.wb_rd, b0.wb_wdata} !== {x.rw, x.rd, x.wd}) begin
                  errs++;
                  $display("FAIL stream_order got rw=%b rd=%0d wd=%h, required rw=%b rd=%0d wd=%h", b0.wb_regwrite, b0.wb_rd, b0.wb_wdata, x.rw, x.rd, x.wd);
               end
            end
         end
         push0();
         @(posedge clk);
         #1;
      end
      vecs++;
      if (sb0.size() != 0) begin
         errs++;
         $display("FAIL stream_lost got %0d pending, required 0", sb0.size());
      end
   endtask

   task automatic test_stall();
      ent0_t ent[3];
      exp0_t x;
      int idx = 0;
      int occ_x[8] = '{0, 1, 2, 2, 2, 1, 1, 0};
      logic ir_x[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
      logic or_x[8] = '{1, 0, 0, 0, 1, 1, 1, 1};
      ent[0] = '{rw: 1'b1, mtr: 1'b1, rdata: 32'hAAAA0001, out: 32'h11110001, rd: 3'd1};
      ent[1] = '{rw: 1'b1, mtr: 1'b0, rdata: 32'hBBBB0002, out: 32'h22220002, rd: 3'd2};
      ent[2] = '{rw: 1'b1, mtr: 1'b0, rdata: 32'hCCCC0003, out: 32'h33330003, rd: 3'd0};
      for (int c = 0; c < 8; c++) begin
         set0(ent[idx > 2 ? 2 : idx], idx < 3, or_x[c], 1'b0);
         @(negedge clk);
         vecs++;
         if ({b0.occupancy, b0.in_ready} !== {2'(occ_x[c]), ir_x[c]}) begin
            errs++;
            $display("FAIL stall_occ cycle %0d got occ=%0d ir=%b, required occ=%0d ir=%b", c, b0.occupancy, b0.in_ready, occ_x[c], ir_x[c]);
         end
         if (b0.out_valid && b0.out_ready) begin
            vecs++;
            if (sb0.size() == 0) begin
               errs++;
               $display("FAIL stall_extra got rd=%0d wd=%h, required no output", b0.wb_rd, b0.wb_wdata);
            end else begin
               x = sb0.pop_front();
               if ({b0.wb_regwrite, b0.wb_rd, b0.wb_wdata} !== {x.rw, x.rd, x.wd}) begin
                  errs++;
                  $display("FAIL stall_order got rw=%b rd=%0d wd=%h, required rw=%b rd=%0d wd=%h", b0.wb_regwrite, b0.wb_rd, b0.wb_wdata, x.rw, x.rd, x.wd);
               end
            end
         end
         if (b0.in_valid && b0.in_ready) idx++;
         push0();
         @(posedge clk);
         #1;
      end
      vecs++;
      if (idx != 3 || sb0.size() != 0) begin
         errs++;
         $display("FAIL stall_lost got accepted=%0d pending=%0d, required 3 0", idx, sb0.size());
      end
   endtask

   task automatic test_flush();
      ent0_t a = '{rw: 1'b1, mtr: 1'b0, rdata: 32'h0, out: 32'hA5A5A5A5, rd: 3'd3};
      ent0_t b = '{rw: 1'b1, mtr: 1'b1, rdata: 32'hB0B0B0B0, out: 32'h0, rd: 3'd4};
      ent0_t d = '{rw: 1'b1, mtr: 1'b1, rdata: 32'hDEADBEEF, out: 32'h0, rd: 3'd6};
      set0(a, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 set0(b, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 set0(d, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      vecs++;
      if ({b0.occupancy, b0.wb_regwrite, b0.wb_rd, b0.wb_wdata} !== {2'd2, 1'b1, 3'd3, 32'hA5A5A5A5}) begin
         errs++;
         $display("FAIL flush_head got occ=%0d rw=%b rd=%0d wd=%h, required 2 1 3 a5a5a5a5", b0.occupancy, b0.wb_regwrite, b0.wb_rd, b0.wb_wdata);
      end
      @(posedge clk);
      #1 set0(d, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      vecs++;
      if ({b0.out_valid, b0.occupancy, b0.in_ready, b0.wb_regwrite} !== {1'b0, 2'd0, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL flush_clear got ov=%b occ=%0d ir=%b rw=%b, required 0 0 1 0", b0.out_valid, b0.occupancy, b0.in_ready, b0.wb_regwrite);
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         vecs++;
         if (b0.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL flush_leak got ov=%b rd=%0d, required ov=0", b0.out_valid, b0.wb_rd);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero();
      logic [2:0] rds[2] = '{3'd0, 3'd6};
      for (int c = 0; c < 2; c++) begin
         set0('{rw: 1'b1, mtr: 1'b0, rdata: 32'h0, out: 32'hFFFFFFFF, rd: rds[c]}, 1'b1, 1'b1, 1'b0);
         b1.in_valid = 1'b1;
         b1.in_regwrite = 1'b1;
         b1.in_memtoreg = 1'b0;
         b1.in_rdata = 32'h0;
         b1.in_out = 32'hFFFFFFFF;
         b1.in_rd = rds[c];
         b1.out_ready = 1'b1;
         @(posedge clk);
         #1 b0.in_valid = 1'b0;
         b1.in_valid = 1'b0;
         @(negedge clk);
         vecs++;
         if ({b0.out_valid, b0.wb_regwrite, b0.wb_wdata} !== {1'b1, c == 1, 32'hFFFFFFFF}) begin
            errs++;
            $display("FAIL zero_ro1 rd=%0d got ov=%b rw=%b wd=%h, required 1 %b ffffffff", rds[c], b0.out_valid, b0.wb_regwrite, b0.wb_wdata, c == 1);
         end
         vecs++;
         if ({b1.out_valid, b1.wb_regwrite, b1.wb_wdata} !== {1'b1, 1'b1, 32'hFFFFFFFF}) begin
            errs++;
            $display("FAIL zero_ro0 rd=%0d got ov=%b rw=%b wd=%h, required 1 1 ffffffff", rds[c], b1.out_valid, b1.wb_regwrite, b1.wb_wdata);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_async_reset();
      ent0_t e = '{rw: 1'b1, mtr: 1'b1, rdata: 32'h0BADF00D, out: 32'h0, rd: 3'd7};
      set0('{rw: 1'b1, mtr: 1'b0, rdata: 32'h0, out: 32'h5555, rd: 3'd1}, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 b0.in_out = 32'h6666;
      b0.in_rd = 3'd2;
      @(posedge clk);
      #1 b0.in_valid = 1'b0;
      @(negedge clk);
      vecs++;
      if (b0.occupancy !== 2'd2) begin
         errs++;
         $display("FAIL areset_fill got occ=%0d, required 2", b0.occupancy);
      end
      #2 rst_n = 1'b0;
      b0.out_ready = 1'b1;
      #1;
      vecs++;
      if ({b0.out_valid, b0.in_ready, b0.wb_regwrite, b0.wb_rd, b0.wb_wdata, b0.occupancy} !== {1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 2'd0}) begin
         errs++;
         $display("FAIL areset_now got ov=%b ir=%b rw=%b rd=%0d wd=%h occ=%0d, required 0 1 0 0 0 0", b0.out_valid, b0.in_ready, b0.wb_regwrite, b0.wb_rd, b0.wb_wdata, b0.occupancy);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1 set0(e, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      vecs++;
      if (b0.out_valid !== 1'b0) begin
         errs++;
         $display("FAIL areset_early got ov=%b, required 0", b0.out_valid);
      end
      @(posedge clk);
      #1 b0.in_valid = 1'b0;
      @(negedge clk);
      vecs++;
      if ({b0.out_valid, b0.wb_regwrite, b0.wb_rd, b0.wb_wdata} !== {1'b1, 1'b1, 3'd7, 32'h0BADF00D}) begin
         errs++;
         $display("FAIL areset_first got ov=%b rw=%b rd=%0d wd=%h, required 1 1 7 0badf00d", b0.out_valid, b0.wb_regwrite, b0.wb_rd, b0.wb_wdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_sweep();
      exp2_t x;
      b2.flush = 1'b0;
      b2.in_regwrite = $urandom_range(0, 1) != 0;
      b2.in_memtoreg = $urandom_range(0, 1) != 0;
      b2.in_rdata = 19'($urandom);
      b2.in_out = 19'($urandom);
      b2.in_rd = 4'($urandom);
      for (int c = 0; c < 400; c++) begin
         b2.in_valid = c < 380 && $urandom_range(0, 3) != 0;
         b2.out_ready = c >= 380 || $urandom_range(0, 2) != 0;
         @(negedge clk);
         vecs++;
         if (b2.out_valid) begin
            if (sb2.size() == 0) begin
               errs++;
               $display("FAIL sweep_extra got rd=%0d wd=%h, required no output", b2.wb_rd, b2.wb_wdata);
            end else begin
               x = sb2[0];
               if ({b2.wb_regwrite, b2.wb_rd, b2.wb_wdata} !== {x.rw & b2.out_ready, x.rd, x.wd}) begin
                  errs++;
                  $display("FAIL sweep_order got rw=%b rd=%0d wd=%h, required rw=%b rd=%0d wd=%h", b2.wb_regwrite, b2.wb_rd, b2.wb_wdata, x.rw & b2.out_ready, x.rd, x.wd);
               end
               if (b2.out_ready) void'(sb2.pop_front());
            end
         end else if (b2.wb_regwrite !== 1'b0) begin
            errs++;
            $display("FAIL sweep_idle got rw=%b, required 0", b2.wb_regwrite);
         end
         if (b2.in_valid && b2.in_ready) begin
            x.rw = b2.in_regwrite && (b2.in_rd != 4'd0);
            x.rd = b2.in_rd;
            x.wd = b2.in_memtoreg ? b2.in_rdata : b2.in_out;
            sb2.push_back(x);
         end
         @(posedge clk);
         #1;
         if (b2.in_valid && sb2.size() > 0) begin
            b2.in_regwrite = $urandom_range(0, 1) != 0;
            b2.in_memtoreg = $urandom_range(0, 1) != 0;
            b2.in_rdata = 19'($urandom);
            b2.in_out = 19'($urandom);
            b2.in_rd = 4'($urandom);
         end
      end
      vecs++;
      if (sb2.size() != 0) begin
         errs++;
         $display("FAIL sweep_lost got %0d pending, required 0", sb2.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got no finish, required finish");
      $fatal(1);
   end

   initial begin
      set0('0, 1'b0, 1'b1, 1'b0);
      b1.flush = 1'b0;
      b1.in_valid = 1'b0;
      b1.in_regwrite = 1'b0;
      b1.in_memtoreg = 1'b0;
      b1.in_rdata = '0;
      b1.in_out = '0;
      b1.in_rd = '0;
      b1.out_ready = 1'b1;
      b2.flush = 1'b0;
      b2.in_valid = 1'b0;
      b2.in_regwrite = 1'b0;
      b2.in_memtoreg = 1'b0;
      b2.in_rdata = '0;
      b2.in_out = '0;
      b2.in_rd = '0;
      b2.out_ready = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_zero();
      test_async_reset();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
